// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle RV32I control FSM (mc_control):
//   - FSM state enum
//   - ALU operation codes (4-bit encoding understood by the datapath ALU)
//   - RV32I opcode constants
//   - datapath mux select encodings (pc_src, alu_src_a, alu_src_b, wb_sel)
//   - instruction class enum + classify() helper used by the decoder
//   - ctrl_t: bundle of every control output driven by the FSM
// ---------------------------------------------------------------------------
package ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH, DECODE, EXECUTE, MEM, WB, TRAP
   } state_e;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_LUI   = 4'd10;
   localparam logic [3:0] ALU_AUIPC = 4'd11;

   // RV32I major opcodes
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // pc_src
   localparam logic [1:0] PC_ALU    = 2'b00;   // alu_result (pc+4)
   localparam logic [1:0] PC_ALUOUT = 2'b01;   // alu_out register (branch/JAL target)
   localparam logic [1:0] PC_JALR   = 2'b10;   // alu_result with bit 0 cleared
   // alu_src_a
   localparam logic [1:0] SRCA_RS1   = 2'b00;
   localparam logic [1:0] SRCA_PC    = 2'b01;
   localparam logic [1:0] SRCA_OLDPC = 2'b10;
   // alu_src_b
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;
   // wb_sel
   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MEM    = 2'b01;
   localparam logic [1:0] WB_PC     = 2'b10;

   typedef enum logic [3:0] {
      CLS_OP, CLS_OPIMM, CLS_LUI, CLS_AUIPC, CLS_LOAD, CLS_STORE,
      CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_FENCE, CLS_BAD
   } cls_e;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       mem_addr_sel;
      logic       ir_we;
      logic       opc_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_op;
      logic       rf_we;
      logic [1:0] wb_sel;
   } ctrl_t;

   // CLS_BAD covers everything the strict decoder refuses: unknown opcodes,
   // SYSTEM, branch funct3 010/011, R-type funct7 outside {0x00,0x20}, and
   // funct7=0x20 on R-type ops other than SUB/SRA.
   function automatic cls_e classify(input logic [6:0] opc,
                                     input logic [2:0] f3,
                                     input logic [6:0] f7);
      cls_e c;
      case (opc)
         OPC_OP: begin
            if (f7 == 7'h00)
               c = CLS_OP;
            else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))
               c = CLS_OP;
            else
               c = CLS_BAD;
         end
         OPC_OPIMM:  c = CLS_OPIMM;
         OPC_LUI:    c = CLS_LUI;
         OPC_AUIPC:  c = CLS_AUIPC;
         OPC_LOAD:   c = CLS_LOAD;
         OPC_STORE:  c = CLS_STORE;
         OPC_BRANCH: c = (f3[2:1] == 2'b01) ? CLS_BAD : CLS_BRANCH;
         OPC_JAL:    c = CLS_JAL;
         OPC_JALR:   c = CLS_JALR;
         OPC_FENCE:  c = CLS_FENCE;
         default:    c = CLS_BAD;   // includes OPC_SYSTEM
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_control_if.sv
// ---------------------------------------------------------------------------
// mc_control_if
// Memory-port handshake between the control FSM (master) and memory (slave).
//   mem_req      master->slave  request active
//   mem_we       master->slave  store (qualified by mem_req)
//   mem_addr_sel master->slave  address source: 0 = pc, 1 = alu_out register
//   mem_ready    slave->master  request completes this cycle
// ---------------------------------------------------------------------------
interface mc_control_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic mem_ready;

   modport master (output mem_req, mem_we, mem_addr_sel, input mem_ready);
   modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_ready);
endinterface

// File: rtl/alu_dec.sv
// ---------------------------------------------------------------------------
// alu_dec
// Combinational ALU operation decoder.
//   cls_i     instruction class (from ctrl_pkg::classify)
//   funct3_i  instr[14:12]
//   f7b5_i    instr[30] (funct7[5]) selects SUB/SRA
//   alu_op_o  ALU code used in EXECUTE
// ---------------------------------------------------------------------------
module alu_dec
   import ctrl_pkg::*;
(
   input  cls_e       cls_i,
   input  logic [2:0] funct3_i,
   input  logic       f7b5_i,
   output logic [3:0] alu_op_o
);

   logic [3:0] arith_op;

   // funct3 map shared by R-type and I-ALU. On I-type, bit 30 is immediate
   // data for ADDI, so it only selects SUB on R-type; for shifts it is the
   // SRAI/SRLI selector in both forms.
   always_comb begin
      arith_op = ALU_ADD;
      case (funct3_i)
         3'b000: arith_op = (f7b5_i && cls_i == CLS_OP) ? ALU_SUB : ALU_ADD;
         3'b001: arith_op = ALU_SLL;
         3'b010: arith_op = ALU_SLT;
         3'b011: arith_op = ALU_SLTU;
         3'b100: arith_op = ALU_XOR;
         3'b101: arith_op = f7b5_i ? ALU_SRA : ALU_SRL;
         3'b110: arith_op = ALU_OR;
         3'b111: arith_op = ALU_AND;
         default: arith_op = ALU_ADD;
      endcase
   end

   always_comb begin
      alu_op_o = ALU_ADD;
      case (cls_i)
         CLS_OP, CLS_OPIMM: alu_op_o = arith_op;
         CLS_LUI:           alu_op_o = ALU_LUI;
         CLS_AUIPC:         alu_op_o = ALU_AUIPC;
         CLS_BRANCH: begin
            // BEQ/BNE compare via zero flag of SUB; signed/unsigned via SLT/SLTU
            case (funct3_i[2:1])
               2'b10:   alu_op_o = ALU_SLT;
               2'b11:   alu_op_o = ALU_SLTU;
               default: alu_op_o = ALU_SUB;
            endcase
         end
         default: alu_op_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control
// Multicycle RV32I control FSM: FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB].
// Drives the datapath mux selects, write enables and ALU op; resolves
// branches from the ALU flags.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instr[31:0]         instruction register (valid from DECODE onward)
//   zero, less_than,    ALU flags used for branch resolution
//   less_than_u
//   mem                 memory handshake (mc_control_if.master)
//   ir_we, opc_we,      IR load, old_pc latch, pc write
//   pc_we
//   pc_src, alu_src_a,  datapath mux selects (encodings in ctrl_pkg)
//   alu_src_b, wb_sel
//   alu_op              ALU operation code
//   rf_we               register file write (never for rd == x0)
//   illegal             sticky illegal-instruction flag
//
// Build option: CTRL_STRICT_DECODE_EN
//   defined   - illegal encodings enter TRAP and raise `illegal` until rst
//   undefined - illegal encodings retire as a NOP; `illegal` is tied to 0
// ---------------------------------------------------------------------------
module mc_control
   import ctrl_pkg::*;
#(
   parameter int ALU_OP_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         instr,
   input  logic                zero,
   input  logic                less_than,
   input  logic                less_than_u,
   mc_control_if.master        mem,
   output logic                ir_we,
   output logic                opc_we,
   output logic                pc_we,
   output logic [1:0]          pc_src,
   output logic [1:0]          alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                rf_we,
   output logic [1:0]          wb_sel,
   output logic                illegal
);

   state_e     state_q, state_d;
   cls_e       cls;
   logic [3:0] dec_op;
   logic       br_taken;
   logic       rd_nz;
   ctrl_t      c;

   // Immediate / rs1 / rs2 fields are consumed by the datapath, not here.
   logic unused_instr_bits;
   assign unused_instr_bits = ^instr[24:15];

   assign cls   = classify(instr[6:0], instr[14:12], instr[31:25]);
   assign rd_nz = |instr[11:7];

   alu_dec u_alu_dec (
      .cls_i    (cls),
      .funct3_i (instr[14:12]),
      .f7b5_i   (instr[30]),
      .alu_op_o (dec_op)
   );

   always_comb begin
      br_taken = 1'b0;
      case (instr[14:12])
         3'b000:  br_taken = zero;            // BEQ
         3'b001:  br_taken = ~zero;           // BNE
         3'b100:  br_taken = less_than;       // BLT
         3'b101:  br_taken = ~less_than;      // BGE
         3'b110:  br_taken = less_than_u;     // BLTU
         3'b111:  br_taken = ~less_than_u;    // BGEU
         default: br_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      c       = '0;
      state_d = state_q;
      case (state_q)
         FETCH: begin
            // pc+4 is set up for the whole request; only the writes wait
            // for mem_ready so nothing changes while memory stalls.
            c.mem_req   = 1'b1;
            c.alu_src_a = SRCA_PC;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALU_ADD;
            c.pc_src    = PC_ALU;
            if (mem.mem_ready) begin
               c.ir_we  = 1'b1;
               c.opc_we = 1'b1;
               c.pc_we  = 1'b1;
               state_d  = DECODE;
            end
         end

         DECODE: begin
            // old_pc + imm lands in alu_out: branch/JAL target for EXECUTE
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_ADD;
            if (cls == CLS_BAD) begin
`ifdef CTRL_STRICT_DECODE_EN
               state_d = TRAP;
`else
               state_d = FETCH;
`endif
            end else begin
               state_d = EXECUTE;
            end
         end

         EXECUTE: begin
            state_d = FETCH;
            case (cls)
               CLS_OP: begin
                  c.alu_op = dec_op;
                  state_d  = WB;
               end
               CLS_OPIMM, CLS_LUI: begin
                  c.alu_src_b = SRCB_IMM;
                  c.alu_op    = dec_op;
                  state_d     = WB;
               end
               CLS_AUIPC: begin
                  c.alu_src_a = SRCA_OLDPC;
                  c.alu_src_b = SRCB_IMM;
                  c.alu_op    = dec_op;
                  state_d     = WB;
               end
               CLS_LOAD, CLS_STORE: begin
                  c.alu_src_b = SRCB_IMM;
                  c.alu_op    = ALU_ADD;
                  state_d     = MEM;
               end
               CLS_BRANCH: begin
                  c.alu_op = dec_op;
                  if (br_taken) begin
                     c.pc_we  = 1'b1;
                     c.pc_src = PC_ALUOUT;
                  end
               end
               CLS_JAL: begin
                  // pc already holds pc+4 from FETCH: that is the link value
                  c.pc_we  = 1'b1;
                  c.pc_src = PC_ALUOUT;
                  c.rf_we  = rd_nz;
                  c.wb_sel = WB_PC;
               end
               CLS_JALR: begin
                  c.alu_src_b = SRCB_IMM;
                  c.alu_op    = ALU_ADD;
                  c.pc_we     = 1'b1;
                  c.pc_src    = PC_JALR;
                  c.rf_we     = rd_nz;
                  c.wb_sel    = WB_PC;
               end
               default: ;   // FENCE: nothing to do
            endcase
         end

         MEM: begin
            c.mem_req      = 1'b1;
            c.mem_addr_sel = 1'b1;
            c.mem_we       = (cls == CLS_STORE);
            if (mem.mem_ready)
               state_d = (cls == CLS_STORE) ? FETCH : WB;
         end

         WB: begin
            c.rf_we  = rd_nz;
            c.wb_sel = (cls == CLS_LOAD) ? WB_MEM : WB_ALUOUT;
            state_d  = FETCH;
         end

         TRAP: state_d = TRAP;

         default: state_d = FETCH;
      endcase

      // Outputs are quiet for every cycle rst is high, including the first,
      // when state_q may still be mid-operation.
      if (rst) c = '0;
   end

   assign mem.mem_req      = c.mem_req;
   assign mem.mem_we       = c.mem_we;
   assign mem.mem_addr_sel = c.mem_addr_sel;
   assign ir_we            = c.ir_we;
   assign opc_we           = c.opc_we;
   assign pc_we            = c.pc_we;
   assign pc_src           = c.pc_src;
   assign alu_src_a        = c.alu_src_a;
   assign alu_src_b        = c.alu_src_b;
   assign alu_op           = ALU_OP_W'(c.alu_op);
   assign rf_we            = c.rf_we;
   assign wb_sel           = c.wb_sel;

`ifdef CTRL_STRICT_DECODE_EN
   assign illegal = (state_q == TRAP) && !rst;
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [31:0] instr = 32'h0;
   logic        zero = 1'b0, less_than = 1'b0, less_than_u = 1'b0;
   logic        ir_we, opc_we, pc_we, rf_we, illegal;
   logic [1:0]  pc_src, alu_src_a, alu_src_b, wb_sel;
   logic [3:0]  alu_op;

   mc_control_if mif ();

   mc_control #(.ALU_OP_W(4)) dut (
      .clk(clk), .rst(rst), .instr(instr), .zero(zero),
      .less_than(less_than), .less_than_u(less_than_u), .mem(mif),
      .ir_we(ir_we), .opc_we(opc_we), .pc_we(pc_we), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal)
   );

   logic [21:0] obs;
   assign obs = {mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_we, opc_we, pc_we,
                 pc_src, alu_src_a, alu_src_b, alu_op, rf_we, wb_sel, illegal};

`ifdef CTRL_STRICT_DECODE_EN
   localparam int BAD_LAT = 0;    // never returns to FETCH
   localparam int BAD_ILL = 10;   // cycles 3..12 of the observation window
`else
   localparam int BAD_LAT = 2;    // DECODE straight back to FETCH
   localparam int BAD_ILL = 0;
`endif

   typedef struct {
      logic [31:0] ins;
      logic        z, lt, ltu;
      int          lat;     // cycles until the next FETCH (0 = none in window)
      logic [3:0]  op;      // EXECUTE-cycle expectations (checked if lat >= 3)
      logic [1:0]  sa, sb;
      logic        pcwe;
      logic [1:0]  psrc;    // checked only when pcwe
      int          rfc;     // cycle of rf_we (0 = never)
      logic [1:0]  wb;
      int          ill;     // cycles with illegal high
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t mk(input logic [31:0] ins, input logic z, input logic lt,
                               input logic ltu, input int lat, input logic [3:0] op,
                               input logic [1:0] sa, input logic [1:0] sb,
                               input logic pcwe, input logic [1:0] psrc,
                               input int rfc, input logic [1:0] wb, input int ill);
      vec_t v;
      v.ins = ins; v.z = z; v.lt = lt; v.ltu = ltu; v.lat = lat; v.op = op;
      v.sa = sa; v.sb = sb; v.pcwe = pcwe; v.psrc = psrc; v.rfc = rfc; v.wb = wb;
      v.ill = ill;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset with the vector's inputs applied, then observe up to 12 cycles.
   task automatic run_vec(input int idx, input vec_t v);
      int         lat, rf_cyc, rf_cnt, ill_cnt, mreq_cnt;
      logic [3:0] e_op;
      logic [1:0] e_sa, e_sb, e_psrc, rf_wb;
      logic       e_pcwe;
      vec_t       e;
      lat = 0; rf_cyc = 0; rf_cnt = 0; ill_cnt = 0; mreq_cnt = 0;
      e_op = '0; e_sa = '0; e_sb = '0; e_psrc = '0; rf_wb = '0; e_pcwe = 1'b0;
      tick();
      rst = 1'b1; instr = v.ins; zero = v.z; less_than = v.lt; less_than_u = v.ltu;
      mif.mem_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_reset_outputs", idx), 32'(obs), 32'h0);
      tick();
      rst = 1'b0;
      exp_q.push_back(v);
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         if (cyc == 1)
            chk($sformatf("v%0d_fetch_ctrl", idx),
                32'({ir_we, opc_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op}),
                32'({1'b1, 1'b1, 1'b1, 2'b00, 2'b01, 2'b10, 4'd0}));
         if (cyc > 1 && mif.mem_req && !mif.mem_addr_sel) begin
            lat = cyc - 1;
            break;
         end
         if (cyc == 3) begin
            e_op = alu_op; e_sa = alu_src_a; e_sb = alu_src_b;
            e_pcwe = pc_we; e_psrc = pc_src;
         end
         if (rf_we) begin
            rf_cnt++;
            if (rf_cyc == 0) begin rf_cyc = cyc; rf_wb = wb_sel; end
         end
         if (illegal) ill_cnt++;
         if (cyc >= 3 && mif.mem_req) mreq_cnt++;
         tick();
      end
      if (exp_q.size() == 0) begin
         chk($sformatf("v%0d_scoreboard_empty", idx), 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(e.lat));
         if (e.lat >= 3) begin
            chk($sformatf("v%0d_exec_alu_op", idx), 32'(e_op), 32'(e.op));
            chk($sformatf("v%0d_exec_src_a", idx), 32'(e_sa), 32'(e.sa));
            chk($sformatf("v%0d_exec_src_b", idx), 32'(e_sb), 32'(e.sb));
            chk($sformatf("v%0d_exec_pc_we", idx), 32'(e_pcwe), 32'(e.pcwe));
            if (e.pcwe)
               chk($sformatf("v%0d_exec_pc_src", idx), 32'(e_psrc), 32'(e.psrc));
         end
         chk($sformatf("v%0d_rf_we_cycle", idx), 32'(rf_cyc), 32'(e.rfc));
         chk($sformatf("v%0d_rf_we_count", idx), 32'(rf_cnt), (e.rfc != 0) ? 32'd1 : 32'd0);
         if (e.rfc != 0)
            chk($sformatf("v%0d_wb_sel", idx), 32'(rf_wb), 32'(e.wb));
         chk($sformatf("v%0d_illegal_cycles", idx), 32'(ill_cnt), 32'(e.ill));
         if (e.lat == 0)
            chk($sformatf("v%0d_trap_mem_req", idx), 32'(mreq_cnt), 32'd0);
      end
   endtask

   initial begin
      mif.mem_ready = 1'b1;
      //         instr         z  lt ltu lat op     sa     sb    pcwe psrc  rfc wb    ill
      vecs.push_back(mk(32'h002081B3, 0, 0, 0, 4, 4'd0,  2'd0, 2'd0, 0, 2'd0, 4, 2'd0, 0)); // add
      vecs.push_back(mk(32'h402081B3, 0, 0, 0, 4, 4'd1,  2'd0, 2'd0, 0, 2'd0, 4, 2'd0, 0)); // sub
      vecs.push_back(mk(32'h4030D093, 0, 0, 0, 4, 4'd7,  2'd0, 2'd1, 0, 2'd0, 4, 2'd0, 0)); // srai
      vecs.push_back(mk(32'h00309093, 0, 0, 0, 4, 4'd2,  2'd0, 2'd1, 0, 2'd0, 4, 2'd0, 0)); // slli
      vecs.push_back(mk(32'h4020D1B3, 0, 0, 0, 4, 4'd7,  2'd0, 2'd0, 0, 2'd0, 4, 2'd0, 0)); // sra
      vecs.push_back(mk(32'h00208463, 1, 0, 0, 3, 4'd1,  2'd0, 2'd0, 1, 2'd1, 0, 2'd0, 0)); // beq taken
      vecs.push_back(mk(32'h00208463, 0, 0, 0, 3, 4'd1,  2'd0, 2'd0, 0, 2'd0, 0, 2'd0, 0)); // beq not
      vecs.push_back(mk(32'h0020C463, 0, 1, 0, 3, 4'd3,  2'd0, 2'd0, 1, 2'd1, 0, 2'd0, 0)); // blt taken
      vecs.push_back(mk(32'h0020F463, 0, 0, 1, 3, 4'd4,  2'd0, 2'd0, 0, 2'd0, 0, 2'd0, 0)); // bgeu not
      vecs.push_back(mk(32'h0000A183, 0, 0, 0, 5, 4'd0,  2'd0, 2'd1, 0, 2'd0, 5, 2'd1, 0)); // lw
      vecs.push_back(mk(32'h0020A023, 0, 0, 0, 4, 4'd0,  2'd0, 2'd1, 0, 2'd0, 0, 2'd0, 0)); // sw
      vecs.push_back(mk(32'h008000EF, 0, 0, 0, 3, 4'd0,  2'd0, 2'd0, 1, 2'd1, 3, 2'd2, 0)); // jal x1
      vecs.push_back(mk(32'h00008067, 0, 0, 0, 3, 4'd0,  2'd0, 2'd1, 1, 2'd2, 0, 2'd0, 0)); // jalr x0
      vecs.push_back(mk(32'h123452B7, 0, 0, 0, 4, 4'd10, 2'd0, 2'd1, 0, 2'd0, 4, 2'd0, 0)); // lui
      vecs.push_back(mk(32'h00001297, 0, 0, 0, 4, 4'd11, 2'd2, 2'd1, 0, 2'd0, 4, 2'd0, 0)); // auipc
      vecs.push_back(mk(32'h00208033, 0, 0, 0, 4, 4'd0,  2'd0, 2'd0, 0, 2'd0, 0, 2'd0, 0)); // add x0
      vecs.push_back(mk(32'h0000000F, 0, 0, 0, 3, 4'd0,  2'd0, 2'd0, 0, 2'd0, 0, 2'd0, 0)); // fence
      vecs.push_back(mk(32'h0000007F, 0, 0, 0, BAD_LAT, 4'd0, 2'd0, 2'd0, 0, 2'd0, 0, 2'd0, BAD_ILL));
      vecs.push_back(mk(32'h00000073, 0, 0, 0, BAD_LAT, 4'd0, 2'd0, 2'd0, 0, 2'd0, 0, 2'd0, BAD_ILL));
      vecs.push_back(mk(32'h202081B3, 0, 0, 0, BAD_LAT, 4'd0, 2'd0, 2'd0, 0, 2'd0, 0, 2'd0, BAD_ILL));
      vecs.push_back(mk(32'h402091B3, 0, 0, 0, BAD_LAT, 4'd0, 2'd0, 2'd0, 0, 2'd0, 0, 2'd0, BAD_ILL));
      vecs.push_back(mk(32'h0020A463, 0, 0, 0, BAD_LAT, 4'd0, 2'd0, 2'd0, 0, 2'd0, 0, 2'd0, BAD_ILL));

      for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

      // Load with three MEM wait cycles
      tick(); rst = 1'b1; instr = 32'h0000A183; mif.mem_ready = 1'b1;
      tick(); rst = 1'b0;                   // cycle 1 FETCH
      tick(); mif.mem_ready = 1'b0;         // cycle 2 DECODE
      tick();                               // cycle 3 EXECUTE
      tick();                               // cycle 4 MEM
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("lw_wait%0d_mem", k),
             32'({mif.mem_req, mif.mem_we, mif.mem_addr_sel, rf_we}), 32'b1010);
         tick();
      end
      mif.mem_ready = 1'b1;                 // cycle 7: MEM completes
      @(negedge clk);
      chk("lw_ready_mem", 32'({mif.mem_req, mif.mem_we, mif.mem_addr_sel}), 32'b101);
      tick();                               // cycle 8 WB
      @(negedge clk);
      chk("lw_wb", 32'({rf_we, wb_sel}), 32'b101);
      tick();                               // cycle 9 FETCH
      @(negedge clk);
      chk("lw_refetch", 32'({mif.mem_req, mif.mem_addr_sel, ir_we}), 32'b101);

      // Store abandoned by a reset pulse during the MEM wait
      begin
         int rf_seen;
         rf_seen = 0;
         tick(); rst = 1'b1; instr = 32'h0020A023; mif.mem_ready = 1'b1;
         tick(); rst = 1'b0;                // cycle 1 FETCH
         tick(); mif.mem_ready = 1'b0;      // cycle 2
         if (rf_we) rf_seen++;
         tick();                            // cycle 3
         if (rf_we) rf_seen++;
         tick();                            // cycle 4 MEM
         @(negedge clk);
         chk("sw_mem", 32'({mif.mem_req, mif.mem_we, mif.mem_addr_sel}), 32'b111);
         if (rf_we) rf_seen++;
         tick();                            // cycle 5 still waiting
         @(negedge clk);
         chk("sw_mem_held", 32'({mif.mem_req, mif.mem_we, mif.mem_addr_sel}), 32'b111);
         tick(); rst = 1'b1;                // cycle 6 reset pulse
         @(negedge clk);
         chk("sw_rst_quiet", 32'(obs), 32'h0);
         tick(); rst = 1'b0;                // cycle 7 FETCH, memory stalls
         @(negedge clk);
         chk("sw_after_rst_fetch", 32'({mif.mem_req, mif.mem_we, mif.mem_addr_sel}), 32'b100);
         chk("fetch_stall_no_writes", 32'({ir_we, opc_we, pc_we, rf_we}), 32'b0000);
         tick(); mif.mem_ready = 1'b1;      // cycle 8 fetch completes
         @(negedge clk);
         chk("fetch_complete", 32'({ir_we, opc_we, pc_we}), 32'b111);
         if (rf_we) rf_seen++;
         chk("sw_no_rf_we", 32'(rf_seen), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1);
   end

endmodule
